// File: rtl/seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// seg7_scan_reader
//
// Reads back a multiplexed, active-high 7-segment display bus. Segment and
// digit-select lines are synchronized, each digit's pattern is accepted once
// it has been stable for STABLE consecutive samples, and the pattern is
// decoded back to a 4-bit hex code. One full scan of all NDIG digits is
// collected into a frame.
//
// Parameters:
//   NDIG    number of multiplexed digits (2..8)
//   STABLE  identical synchronized samples required before capture (2..15)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   seg_in[6:0]  segment lines a..g ([6]=a .. [0]=g), active-high
//   dig_sel      digit enables, active-high, expected one-hot
//   clr          synchronous clear of frame progress
//   cap_valid    one-cycle pulse: a digit was captured
//   cap_idx      index of the captured digit
//   cap_code     decoded hex code of the captured digit (0 when illegal)
//   cap_err      captured pattern was not a legal code
//   bcd_out      last complete frame, digit i at [4i+3:4i]
//   err_out      illegal-pattern flag per digit, last complete frame
//   frame_valid  one-cycle pulse: bcd_out/err_out just updated
// ---------------------------------------------------------------------------
module seg7_scan_reader #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_in,
    input  logic [NDIG-1:0]     dig_sel,
    input  logic                clr,
    output logic                cap_valid,
    output logic [2:0]          cap_idx,
    output logic [3:0]          cap_code,
    output logic                cap_err,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic [NDIG-1:0]     err_out,
    output logic                frame_valid
);

    localparam int SW = NDIG + 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic is_onehot(input logic [NDIG-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

    // Index of the set bit; only meaningful when v is one-hot.
    function automatic logic [2:0] onehot_idx(input logic [NDIG-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Returns {err, code}. Anything outside the 16 legal glyphs is an error
    // with code 0, including the all-off pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h7E:   r = 5'h00;
            7'h30:   r = 5'h01;
            7'h6D:   r = 5'h02;
            7'h79:   r = 5'h03;
            7'h33:   r = 5'h04;
            7'h5B:   r = 5'h05;
            7'h5F:   r = 5'h06;
            7'h70:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h7B:   r = 5'h09;
            7'h77:   r = 5'h0A;
            7'h1F:   r = 5'h0B;
            7'h4E:   r = 5'h0C;
            7'h3D:   r = 5'h0D;
            7'h4F:   r = 5'h0E;
            7'h47:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Stage p0/p1: two-flop synchronizer on {dig_sel, seg_in}
    // -----------------------------------------------------------------------
    logic [SW-1:0] sync_p0;
    logic [SW-1:0] sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {dig_sel, seg_in};
            sync_p1 <= sync_p0;
        end
    end

    logic [NDIG-1:0] dig_p1;
    logic [6:0]      seg_p1;
    logic            onehot_p1;
    logic [2:0]      idx_p1;
    logic [4:0]      dec_p1;

    assign dig_p1    = sync_p1[SW-1:7];
    assign seg_p1    = sync_p1[6:0];
    assign onehot_p1 = is_onehot(dig_p1);
    assign idx_p1    = onehot_idx(dig_p1);
    assign dec_p1    = seg_decode(seg_p1);

    // -----------------------------------------------------------------------
    // Stage p2: stability tracker
    // -----------------------------------------------------------------------
    state_t        state, state_nxt;
    logic [3:0]    run, run_nxt;
    logic [SW-1:0] prev;
    logic          capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            run   <= 4'd0;
            prev  <= '0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            prev  <= sync_p1;
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        capture   = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
            run_nxt   = 4'd0;
        end else if (!onehot_p1) begin
            // Blanking or multi-hot select: nothing trustworthy to read.
            state_nxt = IDLE;
            run_nxt   = 4'd0;
        end else if (sync_p1 != prev) begin
            state_nxt = COUNT;
            run_nxt   = 4'd1;
        end else begin
            case (state)
                COUNT: begin
                    run_nxt = run + 4'd1;
                    if (run == 4'(STABLE - 1)) begin
                        state_nxt = HELD;
                        capture   = 1'b1;
                    end
                end
                // HELD: already captured this dwell. IDLE with an unchanged
                // input (e.g. right after clr) waits for the next change.
                default: begin
                    state_nxt = state;
                    run_nxt   = run;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Stage p3: frame assembly and outputs
    // -----------------------------------------------------------------------
    logic [4*NDIG-1:0] work_code;
    logic [NDIG-1:0]   work_err;
    logic [4*NDIG-1:0] merged_code;
    logic [NDIG-1:0]   merged_err;
    logic [NDIG-1:0]   seen;
    logic [NDIG-1:0]   seen_set;
    logic              frame_done;

    // Working slots with the current capture folded in, so a completing
    // capture lands in bcd_out on the same edge as cap_valid.
    always_comb begin
        merged_code = work_code;
        merged_err  = work_err;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_p1[i]) begin
                merged_code[4*i +: 4] = dec_p1[3:0];
                merged_err[i]         = dec_p1[4];
            end
        end
    end

    assign seen_set   = seen | dig_p1;
    assign frame_done = capture && (&seen_set);

    // Slot contents only matter once seen marks them, so no reset is needed.
    always_ff @(posedge clk) begin
        if (capture) begin
            work_code <= merged_code;
            work_err  <= merged_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen        <= '0;
            cap_valid   <= 1'b0;
            cap_idx     <= 3'd0;
            cap_code    <= 4'd0;
            cap_err     <= 1'b0;
            bcd_out     <= '0;
            err_out     <= '0;
            frame_valid <= 1'b0;
        end else begin
            cap_valid   <= capture;
            frame_valid <= frame_done;
            if (capture) begin
                cap_idx  <= idx_p1;
                cap_code <= dec_p1[3:0];
                cap_err  <= dec_p1[4];
            end
            if (clr) begin
                seen <= '0;
            end else if (frame_done) begin
                seen    <= '0;
                bcd_out <= merged_code;
                err_out <= merged_err;
            end else if (capture) begin
                seen <= seen_set;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_reader
//
// Directed bench for seg7_scan_reader (NDIG=4, STABLE=3). Inputs are driven
// just after a rising edge; outputs are sampled 1 time unit after an edge.
// Capture and frame pulses are counted on the falling edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_reader;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic        clr;
    logic        cap_valid;
    logic [2:0]  cap_idx;
    logic [3:0]  cap_code;
    logic        cap_err;
    logic [15:0] bcd_out;
    logic [3:0]  err_out;
    logic        frame_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int cap_cnt = 0;
    int frame_cnt = 0;
    int cap_snap;
    int frame_snap;

    seg7_scan_reader #(.NDIG(4), .STABLE(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .clr         (clr),
        .cap_valid   (cap_valid),
        .cap_idx     (cap_idx),
        .cap_code    (cap_code),
        .cap_err     (cap_err),
        .bcd_out     (bcd_out),
        .err_out     (err_out),
        .frame_valid (frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cap_valid)   cap_cnt++;
        if (frame_valid) frame_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [3:0] d, input logic [6:0] s, input int n);
        dig_sel = d;
        seg_in  = s;
        repeat (n) tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        dig_sel = 4'b0000;
        seg_in  = 7'h00;
        repeat (3) tick();

        // Reset state
        chk("rst_cap_valid", 32'(cap_valid), 32'd0);
        chk("rst_bcd_out", 32'(bcd_out), 32'h0);
        chk("rst_err_out", 32'(err_out), 32'h0);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Latency and decode: 79h on digit 0 captures after edge 5
        dig_sel = 4'b0001;
        seg_in  = 7'h79;
        repeat (4) tick();
        chk("lat_no_cap_edge4", 32'(cap_valid), 32'd0);
        tick();
        chk("lat_cap_edge5", 32'(cap_valid), 32'd1);
        chk("lat_idx", 32'(cap_idx), 32'd0);
        chk("lat_code", 32'(cap_code), 32'd3);
        chk("lat_err", 32'(cap_err), 32'd0);
        tick();
        chk("lat_pulse_width", 32'(cap_valid), 32'd0);
        repeat (20) tick();
        chk("lat_single_capture", 32'(cap_cnt), 32'd1);
        chk("lat_no_frame", 32'(frame_cnt), 32'd0);

        // Full frame: 1, 2, E, b on digits 0..3
        cap_snap   = cap_cnt;
        frame_snap = frame_cnt;
        show(4'b0001, 7'h30, 8);
        show(4'b0010, 7'h6D, 8);
        show(4'b0100, 7'h4F, 8);
        chk("ff_no_early_frame", 32'(frame_cnt - frame_snap), 32'd0);
        show(4'b1000, 7'h1F, 8);
        chk("ff_captures", 32'(cap_cnt - cap_snap), 32'd4);
        chk("ff_one_frame", 32'(frame_cnt - frame_snap), 32'd1);
        chk("ff_bcd_out", 32'(bcd_out), 32'hBE21);
        chk("ff_err_out", 32'(err_out), 32'h0);

        // Illegal pattern, blanking and multi-hot
        cap_snap   = cap_cnt;
        frame_snap = frame_cnt;
        show(4'b0000, 7'h00, 4);
        show(4'b0001, 7'h7E, 8);
        show(4'b0000, 7'h00, 4);
        show(4'b0010, 7'h5B, 8);
        show(4'b0000, 7'h00, 4);
        dig_sel = 4'b0100;
        seg_in  = 7'h01;
        repeat (5) tick();
        chk("ill_cap_valid", 32'(cap_valid), 32'd1);
        chk("ill_cap_idx", 32'(cap_idx), 32'd2);
        chk("ill_cap_code", 32'(cap_code), 32'd0);
        chk("ill_cap_err", 32'(cap_err), 32'd1);
        repeat (3) tick();
        show(4'b0011, 7'h7E, 10);
        chk("ill_no_cap_multihot", 32'(cap_cnt - cap_snap), 32'd3);
        show(4'b0000, 7'h00, 4);
        show(4'b1000, 7'h77, 8);
        chk("ill_captures", 32'(cap_cnt - cap_snap), 32'd4);
        chk("ill_one_frame", 32'(frame_cnt - frame_snap), 32'd1);
        chk("ill_bcd_out", 32'(bcd_out), 32'hA050);
        chk("ill_err_out", 32'(err_out), 32'b0100);

        // Glitch filter: 7E seen for only 2 samples, then 30 held
        cap_snap = cap_cnt;
        show(4'b0010, 7'h7E, 2);
        show(4'b0010, 7'h30, 5);
        chk("gl_cap_valid", 32'(cap_valid), 32'd1);
        chk("gl_cap_code", 32'(cap_code), 32'd1);
        chk("gl_cap_idx", 32'(cap_idx), 32'd1);
        tick();
        chk("gl_single_capture", 32'(cap_cnt - cap_snap), 32'd1);

        // One-cycle spike inside a held dwell re-captures the same code
        cap_snap = cap_cnt;
        show(4'b0010, 7'h7E, 1);
        show(4'b0010, 7'h30, 5);
        chk("spk_cap_valid", 32'(cap_valid), 32'd1);
        chk("spk_cap_code", 32'(cap_code), 32'd1);
        repeat (3) tick();
        chk("spk_one_recapture", 32'(cap_cnt - cap_snap), 32'd1);

        // clr collides with the 4th digit's capture
        show(4'b0001, 7'h4F, 8);
        show(4'b0100, 7'h6D, 8);
        cap_snap   = cap_cnt;
        frame_snap = frame_cnt;
        dig_sel = 4'b1000;
        seg_in  = 7'h5F;
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_no_cap_valid", 32'(cap_valid), 32'd0);
        chk("clr_no_frame_valid", 32'(frame_valid), 32'd0);
        repeat (10) tick();
        chk("clr_no_capture", 32'(cap_cnt - cap_snap), 32'd0);
        chk("clr_no_frame", 32'(frame_cnt - frame_snap), 32'd0);
        chk("clr_bcd_kept", 32'(bcd_out), 32'hA050);
        show(4'b0000, 7'h00, 4);
        show(4'b1000, 7'h5F, 8);
        chk("clr_seen_cleared", 32'(frame_cnt - frame_snap), 32'd0);
        show(4'b0001, 7'h7F, 8);
        show(4'b0010, 7'h7B, 8);
        show(4'b0100, 7'h70, 8);
        chk("clr_next_frame", 32'(frame_cnt - frame_snap), 32'd1);
        chk("clr_bcd_out", 32'(bcd_out), 32'h6798);
        chk("clr_err_out", 32'(err_out), 32'h0);

        // Asynchronous reset mid-scan with a half-collected frame
        show(4'b0001, 7'h30, 8);
        dig_sel = 4'b0010;
        seg_in  = 7'h30;
        repeat (5) tick();
        chk("mid_cap_before_rst", 32'(cap_valid), 32'd1);
        #2;
        rst_n   = 1'b0;
        dig_sel = 4'b0000;
        seg_in  = 7'h00;
        #1;
        chk("arst_cap_valid", 32'(cap_valid), 32'd0);
        chk("arst_cap_idx", 32'(cap_idx), 32'd0);
        chk("arst_cap_code", 32'(cap_code), 32'd0);
        chk("arst_bcd_out", 32'(bcd_out), 32'h0);
        chk("arst_err_out", 32'(err_out), 32'h0);
        chk("arst_frame_valid", 32'(frame_valid), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        frame_snap = frame_cnt;
        show(4'b0100, 7'h33, 8);
        show(4'b1000, 7'h3D, 8);
        show(4'b0010, 7'h4E, 8);
        chk("post_rst_no_frame", 32'(frame_cnt - frame_snap), 32'd0);
        show(4'b0001, 7'h5B, 8);
        chk("post_rst_frame", 32'(frame_cnt - frame_snap), 32'd1);
        chk("post_rst_bcd_out", 32'(bcd_out), 32'hD4C5);
        chk("post_rst_err_out", 32'(err_out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Reader for a multiplexed, active-high 7-segment display bus: the other end of the team's BCD/hex-to-7-segment decoders.
- Samples the segment lines (a..g) and the one-hot digit-select lines, waits until each digit's pattern is stable, and decodes the pattern back to a 4-bit hex code.
- Collects one full scan of all digits into a frame.
- Used on boards and in benches to read back what a display driver is showing, and to flag illegal segment patterns.

Parameters:
NDIG, 4, number of multiplexed digits (2..8)
STABLE, 3, consecutive identical synchronized samples needed before capture (2..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
seg_in  in  7  segment lines, active-high; [6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g
dig_sel  in  NDIG  digit enables, active-high, expected one-hot; bit i = digit i
clr  in  1  synchronous clear of frame progress
cap_valid  out  1  one-cycle pulse: a digit was captured
cap_idx  out  3  index of the captured digit
cap_code  out  4  decoded hex code of the captured digit (0 when illegal)
cap_err  out  1  captured pattern was not a legal code
bcd_out  out  4*NDIG  last complete frame; digit i at [4i+3:4i]
err_out  out  NDIG  illegal-pattern flag per digit, last complete frame
frame_valid  out  1  one-cycle pulse: bcd_out/err_out just updated

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, synchronizers 0, run counter 0, seen-mask 0, tracker in IDLE.
- Input path: {dig_sel, seg_in} pass through a 2-flop synchronizer; all logic uses the second stage (s2).
- Tracker FSM: IDLE, COUNT, HELD. prev holds the last s2 value.
  - IDLE: entered whenever s2 dig_sel is not one-hot (all-zero = blanking, or multi-hot). Run counter = 0; no capture.
  - COUNT: entered on a one-hot s2 differing from prev. Run = 1; increments each cycle s2 == prev. When run reaches STABLE, go to HELD and pulse cap_valid in that same registered update.
  - HELD: no further capture while s2 is unchanged. Any change goes to COUNT (one-hot) or IDLE (not one-hot). A glitch returning to the same pattern re-captures after a fresh STABLE run.
- Latency: input steady before edge 1 → cap_valid high after edge STABLE+2 (edge 5 for STABLE=3).
- Decode table (a..g bits; legal patterns only):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
  - Any other pattern, including all-off 00: cap_err=1, cap_code=0.
- Capture: cap_idx = position of the set dig_sel bit. Write code and err into the working slot cap_idx and set seen[cap_idx]. Re-capturing a digit before the frame completes overwrites its slot.
- Frame completion:
  - When the capture sets the last missing seen bit, bcd_out/err_out load all working slots, including this capture, on the same edge as cap_valid.
  - frame_valid pulses with cap_valid. seen clears to 0.
  - bcd_out/err_out hold between frames.
- clr: seen clears on the next edge and the tracker goes to IDLE. If clr coincides with a capture, clr wins: no cap_valid, no frame. bcd_out/err_out keep their value.
- Reset mid-scan: everything returns to reset values immediately. The first frame after reset requires all NDIG digits to be captured afresh.
- Digit index ≥ NDIG cannot occur (dig_sel is NDIG wide); cap_idx upper bits are 0 when NDIG<8.

Test Plan:
- Reset: rst_n=0 asynchronously mid-scan, with a frame half-collected → all outputs 0 immediately; after release, the next frame needs all 4 digits.
- Latency/decode: dig_sel=0001, seg_in=7'h79 held → cap_valid exactly after edge 5, cap_idx=0, cap_code=3, cap_err=0; held 20 more cycles → no second pulse.
- Full frame: scan digits 0..3 with 30 h, 6D h, 4F h, 1F h at 8 cycles each → frame_valid pulses once with the digit-3 capture; bcd_out=16'hBE21, err_out=0.
- Illegal/blanking: digit 2 shows 7'h01; blanking (dig_sel=0) between digits; multi-hot 0011 for 10 cycles → digit 2 cap_err=1, code 0, err_out=4'b0100 at frame; no capture during blank or multi-hot.
- Glitch filter: digit 1 pattern 7E h held 2 synchronized cycles, then 30 h held 6 → single capture of code 1 only; a 1-cycle spike inside a HELD dwell followed by return → one extra re-capture of the same code.
- clr collision: assert clr on the same edge the 4th digit would capture → no cap_valid, no frame_valid, bcd_out unchanged, seen=0; the next full scan produces a frame.
